conv3x3_window_gen: RTL

Streaming 3x3 sliding-window generator. It sits upstream of the 3x3 conv MAC and feeds its window input.
- Accepts a raster-order pixel stream for one channel plane, one pixel per handshake.
- Keeps the two previous image rows in internal line buffers.
- Emits packed 3x3 windows, no padding, on a valid/ready interface whose element packing matches the MAC's window input.

---
 rtl/conv3x3_window_gen.sv | 117 +++++++++++
 1 files changed

// File: rtl/conv3x3_window_gen.sv
// Streaming 3x3 sliding-window generator: two line buffers plus a 3x3 column shift register.
// Optional macro WINGEN_STRIDE2_EN adds a stride2 input that emits only every other window position.
module conv3x3_window_gen #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 16,
  parameter int IMG_H  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
`ifdef WINGEN_STRIDE2_EN
  input  logic                   stride2,
`endif
  input  logic                   pix_valid,
  output logic                   pix_ready,
  input  logic signed [DATA_W-1:0] pix_data,
  output logic                   win_valid,
  input  logic                   win_ready,
  output logic [DATA_W*9-1:0]    window_flat,
  output logic                   win_last
);

  localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [XW-1:0] X_MAX = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(IMG_H - 1);
  localparam logic [XW-1:0] X_TWO = XW'(2);
  localparam logic [YW-1:0] Y_TWO = YW'(2);
`ifdef WINGEN_STRIDE2_EN
  localparam logic [XW-1:0] X_LAST2 = XW'(2 * ((IMG_W - 3) / 2) + 2);
  localparam logic [YW-1:0] Y_LAST2 = YW'(2 * ((IMG_H - 3) / 2) + 2);
`endif

  logic [XW-1:0]     x_reg, x_next;
  logic [YW-1:0]     y_reg, y_next;
  logic [DATA_W-1:0] lb0 [IMG_W];
  logic [DATA_W-1:0] lb1 [IMG_W];
  logic [DATA_W-1:0] sr_reg  [9];
  logic [DATA_W-1:0] sr_next [9];
  logic [DATA_W-1:0] col_new [3];
  logic [DATA_W*9-1:0] flat_next;
  logic accept, emit, last_pos;

  assign pix_ready = !win_valid || win_ready;
  assign accept    = pix_valid && pix_ready;

  // Incoming column, top to bottom: row y-2, row y-1, current pixel.
  assign col_new[0] = lb1[x_reg];
  assign col_new[1] = lb0[x_reg];
  assign col_new[2] = pix_data;

  generate
    for (genvar gi = 0; gi < 9; gi++) begin : g_shift
      if (gi % 3 == 2) begin : g_new_col
        assign sr_next[gi] = col_new[gi / 3];
      end else begin : g_old_col
        assign sr_next[gi] = sr_reg[gi + 1];
      end
      assign flat_next[gi*DATA_W +: DATA_W] = sr_next[gi];
    end
  endgenerate

  always_comb begin
    x_next = x_reg;
    y_next = y_reg;
    if (accept) begin
      if (x_reg == X_MAX) begin
        x_next = '0;
        y_next = (y_reg == Y_MAX) ? '0 : y_reg + 1'b1;
      end else begin
        x_next = x_reg + 1'b1;
      end
    end
  end

  always_comb begin
    emit     = (x_reg >= X_TWO) && (y_reg >= Y_TWO);
    last_pos = (x_reg == X_MAX) && (y_reg == Y_MAX);
`ifdef WINGEN_STRIDE2_EN
    // x-2 and y-2 even is the same as x and y even.
    if (stride2) begin
      emit     = emit && !x_reg[0] && !y_reg[0];
      last_pos = (x_reg == X_LAST2) && (y_reg == Y_LAST2);
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_reg       <= '0;
      y_reg       <= '0;
      win_valid   <= 1'b0;
      win_last    <= 1'b0;
      window_flat <= '0;
    end else begin
      x_reg <= x_next;
      y_reg <= y_next;
      // A fresh load takes priority over the downstream consuming the old window.
      if (accept && emit) begin
        window_flat <= flat_next;
        win_last    <= last_pos;
        win_valid   <= 1'b1;
      end else if (win_ready) begin
        win_valid <= 1'b0;
      end
    end
  end

  // Data-path storage carries no reset; stale contents never reach an emitted window.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb1[x_reg] <= lb0[x_reg];
      lb0[x_reg] <= pix_data;
      for (int i = 0; i < 9; i++) sr_reg[i] <= sr_next[i];
    end
  end

endmodule
